// File: rtl/arb_mux.sv
// arb_mux: N-input registered arbiter, round-robin or fixed priority, with valid/ready on every port.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d;
  logic [SEL_W-1:0] lo_sel, hi_sel, gnt;
  logic             lo_any, hi_any, load, acc;
  // Downward scan so the lowest index wins; hi_* only sees channels at or above ptr.
  always_comb begin
    lo_any = 1'b0;
    lo_sel = '0;
    hi_any = 1'b0;
    hi_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_any = 1'b1;
        lo_sel = SEL_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_any = 1'b1;
          hi_sel = SEL_W'(i);
        end
      end
    end
  end
  assign load     = ~valid_q | out_ready;
  assign gnt      = (MODE == 0 && hi_any) ? hi_sel : lo_sel;
  assign acc      = load & lo_any;
  assign in_ready = acc ? N'(1) << gnt : '0;
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < N; i++)
      if (in_ready[i]) data_d = in_data[i*WIDTH +: WIDTH];
    valid_d = acc | (valid_q & ~out_ready);
    sel_d   = acc ? gnt : sel_q;
    ptr_d   = (acc && MODE == 0) ? (int'(gnt) == N - 1 ? '0 : gnt + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;
endmodule
